// File: rtl/pixel_scanner_v11.sv
// +----------------------------------------------------------------------------+
// | Module      : pixel_scanner_v11                                            |
// | Description : Frame timing generator for a small ROIC pixel array:         |
// |               fsync pulse, integration window, row-major readout, gap.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module pixel_scanner_v11 #(
  parameter int ROWS      = 3,
  parameter int COLS      = 3,
  parameter int FSYNC_LEN = 1,
  parameter int INTG_LEN  = 10,
  parameter int PIXEL_LEN = 2,
  parameter int GAP_LEN   = 2
) (
  input  logic       clk,
  input  logic       master_rst,
  output logic       fsync,
  output logic       intg,
  output logic [2:0] row,
  output logic [2:0] col
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FSYNC = 3'd1,
    S_INTG  = 3'd2,
    S_READ  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  localparam logic [15:0] c_fsync_last = 16'(FSYNC_LEN - 1);
  localparam logic [15:0] c_intg_last  = 16'(INTG_LEN - 1);
  localparam logic [15:0] c_pixel_last = 16'(PIXEL_LEN - 1);
  localparam logic [15:0] c_gap_last   = 16'(GAP_LEN - 1);
  localparam logic [2:0]  c_rows       = 3'(ROWS);
  localparam logic [2:0]  c_cols       = 3'(COLS);

  state_t      r_state;
  logic [15:0] r_cnt;

  // Outputs are assigned together with the state they belong to, so they are
  // valid in the same cycle the FSM enters that state.
  always_ff @(posedge clk or negedge master_rst) begin
    if (!master_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      fsync   <= 1'b0;
      intg    <= 1'b0;
      row     <= '0;
      col     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_FSYNC;
          r_cnt   <= '0;
          fsync   <= 1'b1;
        end
        S_FSYNC: begin
          if (r_cnt == c_fsync_last) begin
            r_state <= S_INTG;
            r_cnt   <= '0;
            fsync   <= 1'b0;
            intg    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_INTG: begin
          if (r_cnt == c_intg_last) begin
            r_state <= S_READ;
            r_cnt   <= '0;
            intg    <= 1'b0;
            row     <= 3'd1;
            col     <= 3'd1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_READ: begin
          if (r_cnt == c_pixel_last) begin
            r_cnt <= '0;
            if (col == c_cols) begin
              if (row == c_rows) begin
                r_state <= S_GAP;
                row     <= '0;
                col     <= '0;
              end else begin
                row <= row + 3'd1;
                col <= 3'd1;
              end
            end else begin
              col <= col + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_GAP: begin
          if (r_cnt == c_gap_last) begin
            r_state <= S_FSYNC;
            r_cnt   <= '0;
            fsync   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          fsync   <= 1'b0;
          intg    <= 1'b0;
          row     <= '0;
          col     <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pixel_scanner_v11.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_pixel_scanner_v11                                         |
// | Description : Directed self-checking bench for pixel_scanner_v11, default  |
// |               and overridden (2x4, PIXEL_LEN=1, INTG_LEN=3) instances.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_pixel_scanner_v11;

  logic       clk;
  logic       master_rst;
  logic       master_rst2;
  logic       fsync, intg, fsync2, intg2;
  logic [2:0] row, col, row2, col2;

  int n_checks;
  int n_fail;

  pixel_scanner_v11 dut (
    .clk        (clk),
    .master_rst (master_rst),
    .fsync      (fsync),
    .intg       (intg),
    .row        (row),
    .col        (col)
  );

  pixel_scanner_v11 #(
    .ROWS      (2),
    .COLS      (4),
    .FSYNC_LEN (1),
    .INTG_LEN  (3),
    .PIXEL_LEN (1),
    .GAP_LEN   (2)
  ) dut2 (
    .clk        (clk),
    .master_rst (master_rst2),
    .fsync      (fsync2),
    .intg       (intg2),
    .row        (row2),
    .col        (col2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected {fsync,intg,row,col} at cycle k of a frame (FSYNC_LEN=1, GAP_LEN=2).
  function automatic int exp_vec(input int k, input int intg_len, input int rows,
                                 input int cols, input int pix);
    int p;
    int read_len;
    read_len = rows * cols * pix;
    if (k < 1) return 32'h80;
    if (k < 1 + intg_len) return 32'h40;
    if (k < 1 + intg_len + read_len) begin
      p = (k - 1 - intg_len) / pix;
      return ((p / cols + 1) << 3) | (p % cols + 1);
    end
    return 0;
  endfunction

  function automatic int vec1();
    return int'({fsync, intg, row, col});
  endfunction

  function automatic int vec2();
    return int'({fsync2, intg2, row2, col2});
  endfunction

  initial begin
    int last_rise;
    int rises;
    bit prev_fs;
    bit found;

    n_checks    = 0;
    n_fail      = 0;
    master_rst  = 1'b0;
    master_rst2 = 1'b0;

    repeat (2) begin
      @(negedge clk);
      check("reset_hold", vec1(), 0);
      check("reset_hold2", vec2(), 0);
    end

    // Release, then 200 cycles: exact frame content and fsync period.
    master_rst = 1'b1;
    last_rise  = -1;
    rises      = 0;
    prev_fs    = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      check($sformatf("frame_k%0d", k), vec1(), exp_vec(k % 31, 10, 3, 3, 2));
      if (fsync && !prev_fs) begin
        if (last_rise >= 0) check("fsync_period", k - last_rise, 31);
        last_rise = k;
        rises++;
      end
      prev_fs = fsync;
    end
    check("full_frames", rises - 1, 6);

    // Asynchronous reset between edges while row 2 is being read.
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk);
      #2;
      if (row == 3'd2) found = 1'b1;
    end
    check("row2_reached", int'(found), 1);
    master_rst = 1'b0;
    #1;
    check("async_reset", vec1(), 0);
    @(negedge clk);
    check("async_reset_hold", vec1(), 0);
    master_rst = 1'b1;
    for (int k = 0; k < 31; k++) begin
      @(negedge clk);
      check($sformatf("restart_k%0d", k), vec1(), exp_vec(k, 10, 3, 3, 2));
    end

    // Overridden instance: 2x4 scan, one cycle per pixel, period 14.
    master_rst2 = 1'b1;
    last_rise   = -1;
    prev_fs     = 1'b0;
    for (int k = 0; k < 42; k++) begin
      @(negedge clk);
      check($sformatf("ovr_k%0d", k), vec2(), exp_vec(k % 14, 3, 2, 4, 1));
      if (fsync2 && !prev_fs) begin
        if (last_rise >= 0) check("ovr_period", k - last_rise, 14);
        last_rise = k;
      end
      prev_fs = fsync2;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
